// File: rtl/control_unit.sv
// Hard-wired control sequencer: fetch (T0-T2) and execute (T3-T7) strobes for the single-bus CPU.
// Define CU_ILLEGAL_TRAP_EN to trap undefined opcodes into HALT with a sticky `illegal` flag.
module control_unit #(
  parameter logic [3:0] ADD_OP = 4'b0011,
  parameter logic [3:0] SUB_OP = 4'b0100
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        stop,
  output logic        PCout,
  output logic        ZLowOut,
  output logic        ZHighout,
  output logic        MDRout,
  output logic        Rout,
  output logic        BAout,
  output logic        RCout,
  output logic        MARin,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Rin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic [3:0]  alu_op,
  output logic        run,
  output logic        illegal
);

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAddi = 5'b00101;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  // StHalt resumes when stop drops; StHaltHard waits for clear.
  typedef enum logic [3:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt, StHaltHard
  } state_e;

  state_e state_q, state_d;
  logic   last_step;

  logic [4:0] opcode;
  logic       unused_ir;
  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  logic is_ld, is_ldi, is_st, is_add, is_sub, is_addi, is_nop, is_halt, is_legal;
  assign is_ld    = (opcode == OpLd);
  assign is_ldi   = (opcode == OpLdi);
  assign is_st    = (opcode == OpSt);
  assign is_add   = (opcode == OpAdd);
  assign is_sub   = (opcode == OpSub);
  assign is_addi  = (opcode == OpAddi);
  assign is_nop   = (opcode == OpNop);
  assign is_halt  = (opcode == OpHalt);
  assign is_legal = is_ld | is_ldi | is_st | is_add | is_sub | is_addi | is_nop | is_halt;

`ifdef CU_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= StIdle;
`ifdef CU_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef CU_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    last_step = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    {PCout, ZLowOut, ZHighout, MDRout, Rout, BAout, RCout} = '0;
    {MARin, ZLowIn, ZHighIn, PCin, MDRin, IRin, Yin, Rin} = '0;
    {IncPC, Read, Write, Gra, Grb, Grc} = '0;
    alu_op = '0;
    run    = (state_q != StIdle) && (state_q != StHalt) && (state_q != StHaltHard);

    unique case (state_q)
      StIdle: state_d = StT0;
      StT0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        state_d = StT1;
      end
      StT1: begin
        Read    = 1'b1;
        MDRin   = 1'b1;
        IncPC   = 1'b1;
        state_d = StT2;
      end
      StT2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = StT3;
      end
      StT3: begin
        if (is_ld || is_ldi || is_st) begin
          Grb   = 1'b1;
          BAout = 1'b1;
          Yin   = 1'b1;
        end else if (is_add || is_sub || is_addi) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end
        if (is_halt) begin
          state_d = StHaltHard;
        end else if (!is_legal) begin
`ifdef CU_ILLEGAL_TRAP_EN
          state_d   = StHaltHard;
          illegal_d = 1'b1;
`else
          last_step = 1'b1;
`endif
        end else if (is_nop) begin
          last_step = 1'b1;
        end else begin
          state_d = StT4;
        end
      end
      StT4: begin
        ZLowIn = 1'b1;
        if (is_add || is_sub) begin
          Grc    = 1'b1;
          Rout   = 1'b1;
          alu_op = is_sub ? SUB_OP : ADD_OP;
        end else begin
          RCout  = 1'b1;
          alu_op = ADD_OP;
        end
        state_d = StT5;
      end
      StT5: begin
        ZLowOut = 1'b1;
        if (is_ld || is_st) begin
          MARin   = 1'b1;
          state_d = StT6;
        end else begin
          Gra       = 1'b1;
          Rin       = 1'b1;
          last_step = 1'b1;
        end
      end
      StT6: begin
        MDRin = 1'b1;
        if (is_st) begin
          // Read stays low so MDR captures the register value from the bus.
          Gra  = 1'b1;
          Rout = 1'b1;
        end else begin
          Read = 1'b1;
        end
        state_d = StT7;
      end
      StT7: begin
        if (is_st) begin
          Write = 1'b1;
        end else begin
          MDRout = 1'b1;
          Gra    = 1'b1;
          Rin    = 1'b1;
        end
        last_step = 1'b1;
      end
      StHalt: begin
        if (!stop) state_d = StT0;
      end
      StHaltHard: state_d = StHaltHard;
      default:    state_d = StIdle;
    endcase

    if (last_step) state_d = stop ? StHalt : StT0;
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed instruction sequences then randomized
// instruction/stop/clear stimulus against an instruction-level reference model.
`timescale 1ns/1ps
module tb_control_unit;

  localparam logic [3:0] AluAdd = 4'b0011;
  localparam logic [3:0] AluSub = 4'b0100;

  // Observed vector layout, LSB first: Grc Grb Gra Write Read IncPC Rin Yin IRin MDRin PCin
  // ZHighIn ZLowIn MARin RCout BAout Rout MDRout ZHighout ZLowOut PCout alu_op[4] illegal run.
  localparam logic [26:0] GRC     = 27'h0000001;
  localparam logic [26:0] GRB     = 27'h0000002;
  localparam logic [26:0] GRA     = 27'h0000004;
  localparam logic [26:0] WRITE   = 27'h0000008;
  localparam logic [26:0] READ    = 27'h0000010;
  localparam logic [26:0] INCPC   = 27'h0000020;
  localparam logic [26:0] RIN     = 27'h0000040;
  localparam logic [26:0] YIN     = 27'h0000080;
  localparam logic [26:0] IRIN    = 27'h0000100;
  localparam logic [26:0] MDRIN   = 27'h0000200;
  localparam logic [26:0] ZLOWIN  = 27'h0001000;
  localparam logic [26:0] MARIN   = 27'h0002000;
  localparam logic [26:0] RCOUT   = 27'h0004000;
  localparam logic [26:0] BAOUT   = 27'h0008000;
  localparam logic [26:0] ROUT    = 27'h0010000;
  localparam logic [26:0] MDROUT  = 27'h0020000;
  localparam logic [26:0] ZLOWOUT = 27'h0080000;
  localparam logic [26:0] PCOUT   = 27'h0100000;
  localparam logic [26:0] ALU_ADD = 27'(AluAdd) << 21;
  localparam logic [26:0] ALU_SUB = 27'(AluSub) << 21;
  localparam logic [26:0] ILL     = 27'h2000000;
  localparam logic [26:0] RUN     = 27'h4000000;

  localparam logic [4:0] OPS [8] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                     5'b00100, 5'b00101, 5'b11010, 5'b11011};

  localparam int MIdle = 0, MRun = 1, MHalt = 2, MHard = 3;

  logic        clock = 1'b0;
  logic        clear, stop = 1'b0, clear_next = 1'b0;
  logic [31:0] IR = '0, next_ir = '0;
  logic PCout, ZLowOut, ZHighout, MDRout, Rout, BAout, RCout;
  logic MARin, ZLowIn, ZHighIn, PCin, MDRin, IRin, Yin, Rin;
  logic IncPC, Read, Write, Gra, Grb, Grc, run, illegal;
  logic [3:0] alu_op;
  logic [26:0] obs;

  int   n_vec = 0, n_miss = 0;
  int   m_mode = MIdle, m_step = 0;
  logic m_ill = 1'b0;

  control_unit dut (
    .clock(clock), .clear(clear), .IR(IR), .stop(stop),
    .PCout(PCout), .ZLowOut(ZLowOut), .ZHighout(ZHighout), .MDRout(MDRout), .Rout(Rout),
    .BAout(BAout), .RCout(RCout), .MARin(MARin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Rin(Rin), .IncPC(IncPC),
    .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .alu_op(alu_op),
    .run(run), .illegal(illegal)
  );

  always #5 clock = ~clock;

  assign obs = {run, illegal, alu_op, PCout, ZLowOut, ZHighout, MDRout, Rout, BAout, RCout,
                MARin, ZLowIn, ZHighIn, PCin, MDRin, IRin, Yin, Rin, IncPC, Read, Write,
                Gra, Grb, Grc};

  task automatic check_vec(input string tag, input logic [26:0] got, input logic [26:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %07h expected %07h (mode %0d step %0d t=%0t)",
               tag, got, exp, m_mode, m_step, $time);
    end
  endtask

  // 0 ld, 1 ldi, 2 st, 3 add, 4 sub, 5 addi, 6 nop, 7 halt, 8 undefined
  function automatic int kind(input logic [4:0] op);
    for (int i = 0; i < 8; i++) if (OPS[i] == op) return i;
    return 8;
  endfunction

  function automatic int seq_len(input int c);
    if (c == 0 || c == 2) return 8;
    if (c >= 1 && c <= 5) return 6;
    return 4;
  endfunction

  function automatic logic [26:0] micro(input int c, input int s);
    logic [26:0] seq [8];
    seq = '{default: 27'h0};
    seq[0] = PCOUT | MARIN;
    seq[1] = READ | MDRIN | INCPC;
    seq[2] = MDROUT | IRIN;
    if (c <= 2) begin
      seq[3] = GRB | BAOUT | YIN;
      seq[4] = RCOUT | ALU_ADD | ZLOWIN;
      seq[5] = ZLOWOUT | MARIN;
    end else if (c <= 5) begin
      seq[3] = GRB | ROUT | YIN;
      seq[5] = ZLOWOUT | GRA | RIN;
    end
    case (c)
      0: begin seq[6] = READ | MDRIN; seq[7] = MDROUT | GRA | RIN; end
      1: seq[5] = ZLOWOUT | GRA | RIN;
      2: begin seq[6] = GRA | ROUT | MDRIN; seq[7] = WRITE; end
      3: seq[4] = GRC | ROUT | ALU_ADD | ZLOWIN;
      4: seq[4] = GRC | ROUT | ALU_SUB | ZLOWIN;
      5: seq[4] = RCOUT | ALU_ADD | ZLOWIN;
      default: ;
    endcase
    return seq[s];
  endfunction

  function automatic logic [26:0] expect_vec();
    logic [26:0] v;
    v = m_ill ? ILL : 27'h0;
    if (m_mode == MRun) v = v | RUN | micro(kind(IR[31:27]), m_step);
    return v;
  endfunction

  // Instruction-level model step, evaluated with the inputs seen at the rising edge.
  task automatic advance();
    int c;
    c = kind(IR[31:27]);
    if (!clear) begin
      m_mode = MIdle;
      m_ill  = 1'b0;
    end else begin
      case (m_mode)
        MIdle: begin m_mode = MRun; m_step = 0; end
        MRun: begin
          if (m_step < seq_len(c) - 1) m_step++;
          else if (c == 7) m_mode = MHard;
`ifdef CU_ILLEGAL_TRAP_EN
          else if (c == 8) begin m_mode = MHard; m_ill = 1'b1; end
`endif
          else if (stop) m_mode = MHalt;
          else m_step = 0;
        end
        MHalt: if (!stop) begin m_mode = MRun; m_step = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic step_cycle(input string tag, input logic stop_v);
    @(negedge clock);
    check_vec(tag, obs, expect_vec());
    stop  = stop_v;
    clear = clear_next;
    // Fetch steps must ignore IR; the new instruction appears before the IRin edge.
    if (m_mode == MRun && m_step < 2) IR = $urandom;
    else if (m_mode == MRun && m_step == 2) IR = next_ir;
    @(posedge clock);
    advance();
  endtask

  task automatic do_clear(input int hold);
    @(negedge clock);
    #2 clear = 1'b0;
    #1 check_vec("clear_async", obs, 27'h0);
    m_mode     = MIdle;
    m_ill      = 1'b0;
    clear_next = 1'b0;
    @(posedge clock);
    repeat (hold) step_cycle("clear_hold", 1'b0);
    clear_next = 1'b1;
  endtask

  initial begin
    clear = 1'b1;
    #1 clear = 1'b0;
    repeat (3) step_cycle("reset", 1'b0);
    clear_next = 1'b1;
    step_cycle("release", 1'b0);

    next_ir = 32'h00800055;
    repeat (8) step_cycle("ld", 1'b0);
    next_ir = 32'h10800055;
    repeat (8) step_cycle("st", 1'b0);
    next_ir = 32'h20880000;
    repeat (6) step_cycle("sub", 1'b0);

    next_ir = 32'h00800055;
    repeat (4) step_cycle("ld_stop_pre", 1'b0);
    repeat (4) step_cycle("ld_stop", 1'b1);
    step_cycle("halt_by_stop", 1'b1);
    step_cycle("halt_by_stop", 1'b0);
    next_ir = 32'hD0000000;
    repeat (4) step_cycle("resume_nop", 1'b0);

    next_ir = 32'hF8000000;
    repeat (4) step_cycle("undef_op", 1'b0);
    for (int i = 0; i < 6; i++) step_cycle("undef_after", logic'(i % 2));
    do_clear(2);
    step_cycle("release2", 1'b0);

    next_ir = 32'hD8000000;
    repeat (4) step_cycle("halt_op", 1'b0);
    for (int i = 0; i < 6; i++) step_cycle("halt_op_hold", logic'(i % 2));
    do_clear(1);

    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      next_ir = $urandom;
      if (sel < 8) next_ir[31:27] = OPS[sel];
      if ($urandom_range(0, 150) == 0 || (m_mode == MHard && $urandom_range(0, 3) == 0))
        do_clear($urandom_range(0, 2));
      else
        step_cycle("rand", $urandom_range(0, 5) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
